// File: rtl/srv_defs.sv
// Shared AHB-Lite encodings and the byte-lane helper for the imem responder.
package srv_defs;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [2:0] HSIZE_B = 3'd0;
   localparam logic [2:0] HSIZE_H = 3'd1;
   localparam logic [2:0] HSIZE_W = 3'd2;
   localparam logic [2:0] HSIZE_D = 3'd3;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Little-endian byte enables of a naturally aligned beat inside a doubleword.
   function automatic logic [7:0] byte_en(input logic [2:0] lane, input logic [2:0] size);
      logic [7:0] mask;
      case (size)
         HSIZE_B: mask = 8'h01;
         HSIZE_H: mask = 8'h03;
         HSIZE_W: mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask << lane;
   endfunction

endpackage

// File: rtl/imem_array.sv
// 1R1W synchronous SRAM, 64-bit words with byte write enables.
// A read that collides with a write to the same word returns the merged new bytes.
module imem_array #(
   parameter int    DEPTH     = 4096,
   parameter string INIT_FILE = "",
   parameter int    AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [63:0]   rdata,
   input  logic [7:0]    we,
   input  logic [AW-1:0] waddr,
   input  logic [63:0]   wdata
);

   logic [63:0] mem [DEPTH];
   logic [63:0] merged;

   // Write-first bypass of bytes being committed to the word being read.
   always_comb begin
      merged = mem[raddr];
      for (int b = 0; b < 8; b++) begin
         if (we[b] && (waddr == raddr)) merged[8*b +: 8] = wdata[8*b +: 8];
      end
   end

   // Registered read port (holds its value when not enabled) and byte-lane writes.
   always_ff @(posedge clk) begin
      if (re) rdata <= merged;
      for (int b = 0; b < 8; b++) begin
         if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

endmodule

// File: rtl/imem_ahb_slave.sv
// AHB-Lite responder for the fetch unit's imem port, backed by imem_array.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | no data phase pending; hreadyout=1, hresp=OKAY
//  S_DATA | final cycle of an OKAY data phase; hreadyout=1, writes commit
//  S_WAIT | OKAY data phase being extended; hreadyout=0, counter runs
//  S_ERR1 | first ERROR cycle; hreadyout=0, hresp=ERROR
//  S_ERR2 | second ERROR cycle; hreadyout=1, hresp=ERROR
module imem_ahb_slave
   import srv_defs::*;
#(
   parameter int          MEM_DEPTH   = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0,
   parameter bit          WRITABLE    = 1'b1,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic [2:0]  hsize,
   input  logic        hwrite,
   input  logic [2:0]  hburst,
   input  logic [3:0]  hprot,
   input  logic        hmastlock,
   input  logic        hready,
   input  logic [63:0] hwdata,
   output logic [63:0] hrdata,
   output logic        hreadyout,
   output logic        hresp
);

   localparam int          AW        = $clog2(MEM_DEPTH);
   localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) << 3;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_DATA = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_ERR1 = 3'd3;
   localparam logic [2:0] S_ERR2 = 3'd4;

   logic [2:0]    state;
   logic [3:0]    wait_cnt;
   logic          dp_write;
   logic [AW-1:0] dp_idx;
   logic [7:0]    dp_be;

   logic [31:0]   offset;
   logic          accept;
   logic          misaligned;
   logic          ap_err;
   logic          mem_re;
   logic [7:0]    mem_we;
   logic [63:0]   mem_rdata;

   logic          unused_ok;
   assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0]};

   // Address-phase decode. BASE_ADDR is aligned, so haddr low bits equal offset low bits;
   // an address below BASE_ADDR underflows to a huge offset and is rejected by the range test.
   always_comb begin
      offset = haddr - BASE_ADDR;
      accept = hsel && hready && htrans[1];
      case (hsize)
         HSIZE_H: misaligned = haddr[0];
         HSIZE_W: misaligned = |haddr[1:0];
         HSIZE_D: misaligned = |haddr[2:0];
         default: misaligned = 1'b0;
      endcase
      ap_err = ({1'b0, offset} >= MEM_BYTES) || (hsize > HSIZE_D) || misaligned ||
               (hwrite && !WRITABLE);
   end

   // Transfer sequencing: accept in any ready state, extend OKAYs, two-cycle ERRORs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         wait_cnt <= 4'd0;
         dp_write <= 1'b0;
         dp_idx   <= '0;
         dp_be    <= 8'h00;
      end else begin
         case (state)
            S_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) state <= S_DATA;
            end
            S_ERR1: state <= S_ERR2;
            default: begin
               if (accept) begin
                  dp_write <= hwrite;
                  dp_idx   <= offset[AW+2:3];
                  dp_be    <= byte_en(haddr[2:0], hsize);
                  if (ap_err) begin
                     state <= S_ERR1;
                  end else if (WAIT_STATES > 0) begin
                     state    <= S_WAIT;
                     wait_cnt <= 4'(WAIT_STATES);
                  end else begin
                     state <= S_DATA;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

   // SRAM strobes and bus outputs derived from the current state.
   always_comb begin
      mem_re    = accept && !hwrite && !ap_err && !rst;
      mem_we    = (state == S_DATA && dp_write && !rst) ? dp_be : 8'h00;
      hreadyout = !((state == S_WAIT) || (state == S_ERR1));
      hresp     = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      hrdata    = (((state == S_WAIT) || (state == S_DATA)) && !dp_write) ? mem_rdata : 64'h0;
   end

   imem_array #(
      .DEPTH     (MEM_DEPTH),
      .INIT_FILE (INIT_FILE),
      .AW        (AW)
   ) u_array (
      .clk   (clk),
      .re    (mem_re),
      .raddr (offset[AW+2:3]),
      .rdata (mem_rdata),
      .we    (mem_we),
      .waddr (dp_idx),
      .wdata (hwdata)
   );

endmodule
